fft_stage_sequencer: RTL

- Address/twiddle scheduler for an in-place, memory-based radix-2 decimation-in-time FFT. It time-shares one butterfly_unit over all stages and butterflies.
- Each cycle it issues one butterfly: two operand read addresses, a twiddle index into the W16_k ROM, and delayed write-back addresses.
- It sits between the top-level start/done control and the sample RAM / butterfly / twiddle-ROM datapath.
- Input samples are already in bit-reversed order in RAM. Outputs come out in natural order.

---
 rtl/fft_stage_sequencer.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/fft_stage_sequencer.sv
// Address and twiddle scheduler for an in-place radix-2 DIT FFT.
// Issues one butterfly per cycle and replays its addresses for write-back.
module fft_stage_sequencer #(
    parameter int LOG2N      = 4,
    parameter int BF_LATENCY = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [2:0]       stage,
    output logic             rd_valid,
    output logic [LOG2N-1:0] rd_addr_a,
    output logic [LOG2N-1:0] rd_addr_b,
    output logic [LOG2N-2:0] tw_idx,
    output logic             wr_en,
    output logic [LOG2N-1:0] wr_addr_a,
    output logic [LOG2N-1:0] wr_addr_b
);

    localparam logic [2:0] LAST_STAGE = 3'(LOG2N - 1);
    localparam logic [3:0] DRAIN_LAST = 4'(BF_LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        FINISH
    } state_t;

    state_t           state_q, state_d;
    logic [LOG2N-2:0] k_q, k_d;
    logic [2:0]       stage_q, stage_d;
    logic [3:0]       drain_q, drain_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            k_q     <= '0;
            stage_q <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            stage_q <= stage_d;
            drain_q <= drain_d;
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        stage_d = stage_q;
        drain_d = drain_q;
        unique case (state_q)
            IDLE: begin
                k_d     = '0;
                stage_d = '0;
                drain_d = '0;
                if (start) state_d = RUN;
            end
            RUN: begin
                if (k_q == '1) begin
                    k_d     = '0;
                    drain_d = '0;
                    state_d = DRAIN;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            DRAIN: begin
                // Drain length guarantees the last write lands before the next stage reads
                if (drain_q == DRAIN_LAST) begin
                    if (stage_q == LAST_STAGE) begin
                        stage_d = '0;
                        state_d = FINISH;
                    end else begin
                        stage_d = stage_q + 3'd1;
                        state_d = RUN;
                    end
                end else begin
                    drain_d = drain_q + 4'd1;
                end
            end
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign rd_valid = (state_q == RUN);
    assign busy     = (state_q == RUN) || (state_q == DRAIN);
    assign done     = (state_q == FINISH);
    assign stage    = stage_q;

    logic [LOG2N-1:0] k_ext;
    logic [LOG2N-1:0] half;
    logic [LOG2N-1:0] lo_mask;
    logic [LOG2N-1:0] addr_a_raw;
    logic [LOG2N-2:0] tw_raw;

    // Address a is k with a zero bit inserted at position stage
    always_comb begin
        k_ext      = {1'b0, k_q};
        half       = LOG2N'(1) << stage_q;
        lo_mask    = half - LOG2N'(1);
        addr_a_raw = ((k_ext & ~lo_mask) << 1) | (k_ext & lo_mask);
        tw_raw     = (k_q & lo_mask[LOG2N-2:0]) << (LAST_STAGE - stage_q);
    end

    assign rd_addr_a = rd_valid ? addr_a_raw : '0;
    assign rd_addr_b = rd_valid ? (addr_a_raw | half) : '0;
    assign tw_idx    = rd_valid ? tw_raw : '0;

    logic [BF_LATENCY-1:0] wv_q;
    logic [LOG2N-1:0]      wa_q [BF_LATENCY];
    logic [LOG2N-1:0]      wb_q [BF_LATENCY];

    always_ff @(posedge clock) begin
        if (reset) begin
            wv_q <= '0;
            for (int i = 0; i < BF_LATENCY; i++) begin
                wa_q[i] <= '0;
                wb_q[i] <= '0;
            end
        end else begin
            wv_q[0] <= rd_valid;
            wa_q[0] <= rd_addr_a;
            wb_q[0] <= rd_addr_b;
            for (int i = 1; i < BF_LATENCY; i++) begin
                wv_q[i] <= wv_q[i-1];
                wa_q[i] <= wa_q[i-1];
                wb_q[i] <= wb_q[i-1];
            end
        end
    end

    assign wr_en     = wv_q[BF_LATENCY-1];
    assign wr_addr_a = wa_q[BF_LATENCY-1];
    assign wr_addr_b = wb_q[BF_LATENCY-1];

endmodule
